// File: rtl/core_seq_if.sv
// Stage handshake bundle between the core sequencer and the five pipeline stages.
// The master side is the sequencer: it consumes the stage valids and drives the stage readys.
`timescale 1ns/1ps
interface core_seq_if;
  logic i_ifu_valid;
  logic i_idu_valid;
  logic i_exu_valid;
  logic i_lsu_valid;
  logic i_wbu_valid;
  logic i_idu_ctr_ram_en;
  logic i_idu_ctr_halt;
  logic o_ifu_ready;
  logic o_idu_ready;
  logic o_exu_ready;
  logic o_lsu_ready;
  logic o_wbu_ready;

  modport master (
    input  i_ifu_valid, i_idu_valid, i_exu_valid, i_lsu_valid, i_wbu_valid,
    input  i_idu_ctr_ram_en, i_idu_ctr_halt,
    output o_ifu_ready, o_idu_ready, o_exu_ready, o_lsu_ready, o_wbu_ready
  );

  modport slave (
    output i_ifu_valid, i_idu_valid, i_exu_valid, i_lsu_valid, i_wbu_valid,
    output i_idu_ctr_ram_en, i_idu_ctr_halt,
    input  o_ifu_ready, o_idu_ready, o_exu_ready, o_lsu_ready, o_wbu_ready
  );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle stage sequencer: walks one instruction through IF/ID/EX/[MEM]/WB,
// counts retirements and traps a hung LSU access into a terminal error state.
`timescale 1ns/1ps
module core_seq #(
  parameter int CNT_WIDTH   = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  input  logic                 i_seq_start,
  core_seq_if.master           bus,
  output logic                 o_pc_upd_en,
  output logic [2:0]           o_seq_state,
  output logic                 o_seq_halt,
  output logic                 o_seq_err,
  output logic [CNT_WIDTH-1:0] o_inst_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } state_e;

  localparam int WD_W = 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_e                 state_q, state_d;
  logic                   ram_en_q, ram_en_d;
  logic                   halt_q, halt_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   pc_upd_q, pc_upd_d;
  logic                   retire;

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q  <= S_IDLE;
      ram_en_q <= 1'b0;
      halt_q   <= 1'b0;
      wdog_q   <= '0;
      cnt_q    <= '0;
      pc_upd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ram_en_q <= ram_en_d;
      halt_q   <= halt_d;
      wdog_q   <= wdog_d;
      cnt_q    <= cnt_d;
      pc_upd_q <= pc_upd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ram_en_d = ram_en_q;
    halt_d   = halt_q;
    wdog_d   = wdog_q;
    retire   = 1'b0;
    case (state_q)
      S_IDLE: if (i_seq_start) state_d = S_IF;
      S_IF:   if (bus.i_ifu_valid) state_d = S_ID;
      S_ID: begin
        if (bus.i_idu_valid) begin
          state_d  = S_EX;
          ram_en_d = bus.i_idu_ctr_ram_en;
          halt_d   = bus.i_idu_ctr_halt;
        end
      end
      S_EX: begin
        if (bus.i_exu_valid) begin
          state_d = ram_en_q ? S_MEM : S_WB;
          wdog_d  = '0;
        end
      end
      S_MEM: begin
        // A late valid on the final allowed cycle still completes the access.
        if (bus.i_lsu_valid) begin
          state_d = S_WB;
        end else begin
          wdog_d = wdog_q + 1'b1;
          if (wdog_q == WD_LAST) state_d = S_ERR;
        end
      end
      S_WB: begin
        if (bus.i_wbu_valid) begin
          state_d = halt_q ? S_HALT : S_IF;
          retire  = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase
    cnt_d    = cnt_q + CNT_WIDTH'(retire);
    pc_upd_d = retire && !halt_q;
  end

  assign bus.o_ifu_ready = (state_q == S_IF);
  assign bus.o_idu_ready = (state_q == S_ID);
  assign bus.o_exu_ready = (state_q == S_EX);
  assign bus.o_lsu_ready = (state_q == S_MEM);
  assign bus.o_wbu_ready = (state_q == S_WB);

  assign o_pc_upd_en = pc_upd_q;
  assign o_seq_state = state_q;
  assign o_seq_halt  = (state_q == S_HALT);
  assign o_seq_err   = (state_q == S_ERR);
  assign o_inst_cnt  = cnt_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed scoreboard bench for core_seq: each stimulus cycle queues the expected
// post-edge outputs, and an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_core_seq;
  localparam int CW = 4;
  localparam int TO = 4;

  localparam int IDLE = 0, IF = 1, ID = 2, EX = 3, MEM = 4, WB = 5, HALT = 6, ERR = 7;

  localparam logic [8:0] R_RST = 9'h100;
  localparam logic [8:0] ST    = 9'h080;
  localparam logic [8:0] V_IF  = 9'h040;
  localparam logic [8:0] V_ID  = 9'h020;
  localparam logic [8:0] V_EX  = 9'h010;
  localparam logic [8:0] V_LS  = 9'h008;
  localparam logic [8:0] V_WB  = 9'h004;
  localparam logic [8:0] C_RAM = 9'h002;
  localparam logic [8:0] C_HLT = 9'h001;
  localparam logic [8:0] NONE  = 9'h000;

  typedef struct {
    string      name;
    int         st;
    logic       pc;
    int         cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic pc_upd;
  logic [2:0] seq_state;
  logic seq_halt;
  logic seq_err;
  logic [CW-1:0] inst_cnt;

  core_seq_if bus();

  core_seq #(.CNT_WIDTH(CW), .TIMEOUT_CYC(TO)) dut (
    .i_sys_clk   (clk),
    .i_sys_rst   (rst),
    .i_seq_start (start),
    .bus         (bus),
    .o_pc_upd_en (pc_upd),
    .o_seq_state (seq_state),
    .o_seq_halt  (seq_halt),
    .o_seq_err   (seq_err),
    .o_inst_cnt  (inst_cnt)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [4:0] rdy_of(int s);
    case (s)
      IF:      return 5'b10000;
      ID:      return 5'b01000;
      EX:      return 5'b00100;
      MEM:     return 5'b00010;
      WB:      return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  // Monitor: compares the outputs produced by each edge against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [4:0] a_rdy, r_rdy;
      logic a_halt, r_halt, a_err, r_err;
      e      = exp_q.pop_front();
      a_rdy  = {bus.o_ifu_ready, bus.o_idu_ready, bus.o_exu_ready, bus.o_lsu_ready, bus.o_wbu_ready};
      r_rdy  = rdy_of(e.st);
      a_halt = seq_halt;
      a_err  = seq_err;
      r_halt = (e.st == HALT);
      r_err  = (e.st == ERR);
      n_checks++;
      if (seq_state !== 3'(e.st) || a_rdy !== r_rdy || pc_upd !== e.pc ||
          a_halt !== r_halt || a_err !== r_err || inst_cnt !== CW'(e.cnt)) begin
        n_errors++;
        $display("FAIL %s: got st=%0d rdy=%b pc=%b halt=%b err=%b cnt=%0d, required st=%0d rdy=%b pc=%b halt=%b err=%b cnt=%0d",
                 e.name, seq_state, a_rdy, pc_upd, a_halt, a_err, inst_cnt,
                 e.st, r_rdy, e.pc, r_halt, r_err, e.cnt);
      end
    end
  end

  task automatic step(input string name, input logic [8:0] in, input int es,
                      input logic epc, input int ecnt);
    exp_t e;
    @(negedge clk);
    rst                  = in[8];
    start                = in[7];
    bus.i_ifu_valid      = in[6];
    bus.i_idu_valid      = in[5];
    bus.i_exu_valid      = in[4];
    bus.i_lsu_valid      = in[3];
    bus.i_wbu_valid      = in[2];
    bus.i_idu_ctr_ram_en = in[1];
    bus.i_idu_ctr_halt   = in[0];
    e.name = name;
    e.st   = es;
    e.pc   = epc;
    e.cnt  = ecnt;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, required finish before 100000ns");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    bus.i_ifu_valid = 1'b0; bus.i_idu_valid = 1'b0; bus.i_exu_valid = 1'b0;
    bus.i_lsu_valid = 1'b0; bus.i_wbu_valid = 1'b0;
    bus.i_idu_ctr_ram_en = 1'b0; bus.i_idu_ctr_halt = 1'b0;

    // Reset state and IDLE ignoring stage valids
    step("reset",        R_RST,       IDLE, 0, 0);
    step("idle_hold",    NONE,        IDLE, 0, 0);
    step("idle_spur",    V_IF | V_WB, IDLE, 0, 0);

    // ALU instruction: 1,2,3,5,1 with a single PC pulse
    step("alu_start",    ST,          IF,   0, 0);
    step("alu_if_stall", NONE,        IF,   0, 0);
    step("alu_if",       V_IF,        ID,   0, 0);
    step("alu_id",       V_ID,        EX,   0, 0);
    step("alu_ex",       V_EX,        WB,   0, 0);
    step("alu_wb",       V_WB,        IF,   1, 1);
    step("alu_pc_drop",  NONE,        IF,   0, 1);

    // Load with LSU valid two cycles late: MEM held three cycles
    step("ld_if",        V_IF,        ID,   0, 1);
    step("ld_id",        V_ID | C_RAM, EX,  0, 1);
    step("ld_ex",        V_EX,        MEM,  0, 1);
    step("ld_mem1",      NONE,        MEM,  0, 1);
    step("ld_mem2",      NONE,        MEM,  0, 1);
    step("ld_mem3",      V_LS,        WB,   0, 1);
    step("ld_wb",        V_WB,        IF,   1, 2);

    // Watchdog: silent LSU reaches ERR after exactly four MEM cycles
    step("wd_if",        V_IF,        ID,   0, 2);
    step("wd_id",        V_ID | C_RAM, EX,  0, 2);
    step("wd_ex",        V_EX,        MEM,  0, 2);
    step("wd_mem1",      NONE,        MEM,  0, 2);
    step("wd_mem2",      NONE,        MEM,  0, 2);
    step("wd_mem3",      NONE,        MEM,  0, 2);
    step("wd_mem4",      NONE,        ERR,  0, 2);
    step("err_start",    ST,          ERR,  0, 2);
    step("err_spur",     ST | V_LS | V_WB | V_IF, ERR, 0, 2);

    // Watchdog rerun: valid on the fourth MEM cycle wins
    step("wd2_reset",    R_RST,       IDLE, 0, 0);
    step("wd2_start",    ST,          IF,   0, 0);
    step("wd2_if",       V_IF,        ID,   0, 0);
    step("wd2_id",       V_ID | C_RAM, EX,  0, 0);
    step("wd2_ex",       V_EX,        MEM,  0, 0);
    step("wd2_mem1",     NONE,        MEM,  0, 0);
    step("wd2_mem2",     NONE,        MEM,  0, 0);
    step("wd2_mem3",     NONE,        MEM,  0, 0);
    step("wd2_mem4",     V_LS,        WB,   0, 0);
    step("wd2_wb",       V_WB,        IF,   1, 1);

    // Watchdog must restart from zero on the next MEM entry
    step("wd3_if",       V_IF,        ID,   0, 1);
    step("wd3_id",       V_ID | C_RAM, EX,  0, 1);
    step("wd3_ex",       V_EX,        MEM,  0, 1);
    step("wd3_mem1",     NONE,        MEM,  0, 1);
    step("wd3_mem2",     V_LS,        WB,   0, 1);
    step("wd3_wb",       V_WB,        IF,   1, 2);

    // EX stall with spurious valids and decode controls from other stages
    step("st_if",        V_IF,        ID,   0, 2);
    step("st_id",        V_ID,        EX,   0, 2);
    for (int i = 0; i < 10; i++)
      step("st_ex_stall", (i % 2 == 0) ? (ST | V_IF | V_ID | V_LS | V_WB | C_RAM | C_HLT) : NONE,
           EX, 0, 2);
    step("st_ex",        V_EX,        WB,   0, 2);
    step("st_wb",        V_WB,        IF,   1, 3);

    // Halt instruction: retires without a PC pulse and parks in HALT
    step("h_if",         V_IF,        ID,   0, 3);
    step("h_id",         V_ID | C_HLT, EX,  0, 3);
    step("h_ex",         V_EX,        WB,   0, 3);
    step("h_wb",         V_WB,        HALT, 0, 4);
    for (int i = 0; i < 20; i++)
      step("h_park", ST | V_IF | V_ID | V_EX | V_LS | V_WB, HALT, 0, 4);

    // Counter wrap: 17 retirements on a 4-bit counter
    step("wr_reset",     R_RST,       IDLE, 0, 0);
    step("wr_start",     ST,          IF,   0, 0);
    for (int k = 1; k <= 17; k++) begin
      step("wr_if", V_IF, ID, 0, (k - 1) % 16);
      step("wr_id", V_ID, EX, 0, (k - 1) % 16);
      step("wr_ex", V_EX, WB, 0, (k - 1) % 16);
      step("wr_wb", V_WB, IF, 1, k % 16);
    end

    // Reset mid-EX has priority over the EX transition
    step("rx_if",        V_IF,        ID,   0, 1);
    step("rx_id",        V_ID | C_RAM | C_HLT, EX, 0, 1);
    step("rx_reset",     R_RST | V_EX, IDLE, 0, 0);
    step("rx_idle",      NONE,        IDLE, 0, 0);

    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/core_seq.md
# core_seq

Multi-cycle stage sequencer for the L1 core. It steps one instruction at a time through IFU, IDU, EXU, the optional LSU and WBU, driving each stage's `i_sys_ready` and consuming its `o_sys_valid`. It skips the memory stage for instructions that do not access RAM, and halts after retiring a halt instruction. It also counts retired instructions and detects a hung LSU access with a watchdog.

## Interface

Parameters:
- `CNT_WIDTH`, 32, width of the retired-instruction counter.
- `TIMEOUT_CYC`, 16, maximum cycles spent in MEM waiting for `i_lsu_valid`; legal range 1 to 2^16-1.

Ports:
- `i_sys_clk`  in  1  core clock.
- `i_sys_rst`  in  1  reset, synchronous, active-high.
- `i_seq_start`  in  1  leave IDLE and begin fetching.
- `i_ifu_valid`  in  1  IFU done (IFU `o_sys_valid`).
- `i_idu_valid`  in  1  IDU done.
- `i_exu_valid`  in  1  EXU done.
- `i_lsu_valid`  in  1  LSU done.
- `i_wbu_valid`  in  1  WBU done.
- `i_idu_ctr_ram_en`  in  1  decoded instruction accesses RAM; valid while `i_idu_valid`.
- `i_idu_ctr_halt`  in  1  decoded instruction is halt (ebreak); valid while `i_idu_valid`.
- `o_ifu_ready`  out  1  drives IFU `i_sys_ready`.
- `o_idu_ready`  out  1  drives IDU `i_sys_ready`.
- `o_exu_ready`  out  1  drives EXU `i_sys_ready`.
- `o_lsu_ready`  out  1  drives LSU `i_sys_ready`.
- `o_wbu_ready`  out  1  drives WBU `i_sys_ready`.
- `o_pc_upd_en`  out  1  one-cycle pulse that commits the next PC.
- `o_seq_state`  out  3  current state encoding, for debug.
- `o_seq_halt`  out  1  sequencer is in HALT.
- `o_seq_err`  out  1  sequencer is in ERR (LSU timeout).
- `o_inst_cnt`  out  CNT_WIDTH  retired-instruction count.

## Operation

- States and encodings: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6, ERR=7. The state register is the only state-machine storage.
- Ready outputs are a pure decode of the registered state. Exactly one `o_*_ready` is high in IF, ID, EX, MEM or WB. All are low in IDLE, HALT and ERR.
- State transitions are evaluated on each rising edge:
  - IDLE → IF when `i_seq_start`.
  - IF → ID when `i_ifu_valid`.
  - ID → EX when `i_idu_valid`. On this edge, `i_idu_ctr_ram_en` is captured into `r_ram_en` and `i_idu_ctr_halt` into `r_halt`.
  - EX → MEM when `i_exu_valid` and `r_ram_en`. EX → WB when `i_exu_valid` and not `r_ram_en`.
  - MEM → WB when `i_lsu_valid`. MEM → ERR when the watchdog expires.
  - WB → HALT when `i_wbu_valid` and `r_halt`. WB → IF when `i_wbu_valid` and not `r_halt`.
  - HALT and ERR are terminal; only reset leaves them.
- Without the relevant valid, the state holds and the current ready stays high (stall).
- A valid from any stage other than the active one is ignored. `i_seq_start` is ignored outside IDLE.
- Retirement on WB completion:
  - `o_inst_cnt` increments by 1 and wraps modulo 2^CNT_WIDTH.
  - `o_pc_upd_en` pulses high for 1 cycle only when `r_halt`=0.
- Watchdog:
  - The counter clears on entry to MEM and increments on each MEM cycle without `i_lsu_valid`.
  - On the TIMEOUT_CYC-th consecutive MEM cycle with no valid, the next state is ERR.
  - If `i_lsu_valid` arrives on that same cycle, valid wins and the next state is WB.
- Reset values: state IDLE; all readys 0; `o_pc_upd_en` 0; `o_seq_halt` 0; `o_seq_err` 0; `o_inst_cnt` 0; `r_ram_en`, `r_halt` and the watchdog counter 0.

## Timing

- Every output and capture register updates on the rising edge of `i_sys_clk`. No combinational path from any input to any output.
- Each stage takes at least 1 cycle.
- Throughput with each stage answering in its first cycle:
  - 4 cycles per instruction without RAM (IF, ID, EX, WB).
  - 5 cycles per instruction with RAM.
- `o_pc_upd_en` is high in the cycle after the WB→IF edge, which is the first IF cycle of the next instruction. The PC register must sample it on the following edge, before IFU reuses the PC.
- `o_inst_cnt` shows the new value in that same cycle.
- Reset asserted mid-instruction, in any state, gives IDLE with all reset values on the next edge; reset has priority over every transition.

## Test plan

- ALU instruction (ram_en=0): reset, start, each valid returned 1 cycle after its ready. Required: state sequence 1,2,3,5,1; `o_pc_upd_en` single pulse; `o_inst_cnt`=1; `o_lsu_ready` never high.
- Load instruction (ram_en=1) with `i_lsu_valid` 2 cycles late. Required: MEM held 3 cycles with `o_lsu_ready`=1, then WB; `o_inst_cnt`=1.
- Watchdog with TIMEOUT_CYC=4:
  - LSU silent: ERR after exactly 4 MEM cycles; `o_seq_err`=1, all readys 0; `i_seq_start` ignored.
  - Rerun with valid on the 4th MEM cycle: goes to WB, no error.
- Halt instruction (halt=1 at ID): after WB, state HALT and `o_seq_halt`=1. `o_pc_upd_en` stays 0 and `o_inst_cnt` increments. Stays HALT for 20 cycles despite start.
- Stalls and spurious valids: hold `i_exu_valid` low 10 cycles while pulsing the other four valids. Required: state stays EX, `o_exu_ready` stays high, no other ready rises.
- Reset mid-EX gives IDLE and counters 0 next cycle. Separately, CNT_WIDTH=4 with 17 retirements gives `o_inst_cnt`=1 (wrap).
